// File: rtl/program_mem_pkg.sv
// program_mem_pkg: shared FSM states, NOP word and parity helper for program_mem.
package program_mem_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam int NOP = 0;

    // Even-parity bit: makes the total count of ones across data+bit even.
    function automatic logic even_par(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/program_mem_if.sv
// program_mem_if: fetch and burn port bundle for program_mem.
// Fetch: rom_addr_in -> rom_data_out (registered), busy stalls the core.
// Burn: prog_start/prog_base open a session, prog_valid/prog_ready move words,
// prog_done/prog_err/prog_sum report the outcome.
// With PROGRAM_MEM_PARITY_EN defined, parity_err flags corrupted fetches.
interface program_mem_if #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 11
);
    logic [ADDR_W-1:0] rom_addr_in;
    logic [DATA_W-1:0] rom_data_out;
    logic              busy;
    logic              prog_start;
    logic [ADDR_W-1:0] prog_base;
    logic              prog_valid;
    logic [DATA_W-1:0] prog_data;
    logic              prog_last;
    logic              prog_ready;
    logic              prog_done;
    logic              prog_err;
    logic [DATA_W-1:0] prog_sum;
`ifdef PROGRAM_MEM_PARITY_EN
    logic              parity_err;

    modport master (
        output rom_addr_in, prog_start, prog_base, prog_valid, prog_data, prog_last,
        input  rom_data_out, busy, prog_ready, prog_done, prog_err, prog_sum, parity_err
    );
    modport slave (
        input  rom_addr_in, prog_start, prog_base, prog_valid, prog_data, prog_last,
        output rom_data_out, busy, prog_ready, prog_done, prog_err, prog_sum, parity_err
    );
`else
    modport master (
        output rom_addr_in, prog_start, prog_base, prog_valid, prog_data, prog_last,
        input  rom_data_out, busy, prog_ready, prog_done, prog_err, prog_sum
    );
    modport slave (
        input  rom_addr_in, prog_start, prog_base, prog_valid, prog_data, prog_last,
        output rom_data_out, busy, prog_ready, prog_done, prog_err, prog_sum
    );
`endif
endinterface

// File: rtl/program_mem_loader.sv
// program_mem_loader: burn-session FSM with write pointer, checksum and overflow flag.
// Inputs: clk, reset, i_prog_start/base/valid/data/last from the burn port.
// Outputs: o_busy, o_prog_ready, o_prog_done, o_prog_err, o_prog_sum, and the
// o_we/o_waddr/o_wdata write strobe into the storage array.
module program_mem_loader
    import program_mem_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_prog_start,
    input  logic [ADDR_W-1:0] i_prog_base,
    input  logic              i_prog_valid,
    input  logic [DATA_W-1:0] i_prog_data,
    input  logic              i_prog_last,
    output logic              o_busy,
    output logic              o_prog_ready,
    output logic              o_prog_done,
    output logic              o_prog_err,
    output logic [DATA_W-1:0] o_prog_sum,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [DATA_W-1:0] o_wdata
);
    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
    logic [DATA_W-1:0] r_sum, w_sum_nxt;
    logic              r_err, w_err_nxt;
    logic              w_accept, w_at_end, w_base_oob;

    assign w_accept   = (r_state == LOAD) && i_prog_valid;
    assign w_at_end   = r_ptr == ADDR_W'(DEPTH - 1);
    assign w_base_oob = {1'b0, i_prog_base} >= (ADDR_W + 1)'(DEPTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_sum   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sum   <= w_sum_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Filling the last implemented word without prog_last is an overflow:
    // the word is kept, but the session ends rather than wrapping to 0.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sum_nxt   = r_sum;
        w_err_nxt   = r_err;
        if (r_state == IDLE && i_prog_start) begin
            w_ptr_nxt   = i_prog_base;
            w_sum_nxt   = '0;
            w_err_nxt   = w_base_oob;
            w_state_nxt = w_base_oob ? DONE : LOAD;
        end else if (w_accept) begin
            w_ptr_nxt   = r_ptr + 1'b1;
            w_sum_nxt   = r_sum + i_prog_data;
            w_err_nxt   = r_err | (w_at_end && !i_prog_last);
            w_state_nxt = (i_prog_last || w_at_end) ? DONE : LOAD;
        end else if (r_state != LOAD) begin
            w_state_nxt = IDLE;
        end
    end

    assign o_busy       = r_state != IDLE;
    assign o_prog_ready = r_state == LOAD;
    assign o_prog_done  = r_state == DONE;
    assign o_prog_err   = r_err;
    assign o_prog_sum   = r_sum;
    assign o_we         = w_accept;
    assign o_waddr      = r_ptr;
    assign o_wdata      = i_prog_data;

endmodule

// File: rtl/program_mem.sv
// program_mem: writable instruction store with registered fetch and in-system burn port.
// Ports: clk, reset (sync, active-high), bus (program_mem_if.slave: fetch + burn).
// Fetches return NOP while busy or for addresses >= DEPTH.
// Define PROGRAM_MEM_PARITY_EN to store an even-parity bit per word and flag
// corrupted fetches on bus.parity_err.
module program_mem
    import program_mem_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048
) (
    input  logic          clk,
    input  logic          reset,
    program_mem_if.slave  bus
);
`ifdef PROGRAM_MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [MEM_W-1:0]  r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic [MEM_W-1:0]  w_rword;
    logic [MEM_W-1:0]  w_wword;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_busy;
    logic              w_mask;

    program_mem_loader #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_loader (
        .clk          (clk),
        .reset        (reset),
        .i_prog_start (bus.prog_start),
        .i_prog_base  (bus.prog_base),
        .i_prog_valid (bus.prog_valid),
        .i_prog_data  (bus.prog_data),
        .i_prog_last  (bus.prog_last),
        .o_busy       (w_busy),
        .o_prog_ready (bus.prog_ready),
        .o_prog_done  (bus.prog_done),
        .o_prog_err   (bus.prog_err),
        .o_prog_sum   (bus.prog_sum),
        .o_we         (w_we),
        .o_waddr      (w_waddr),
        .o_wdata      (w_wdata)
    );

`ifdef PROGRAM_MEM_PARITY_EN
    assign w_wword = {even_par(32'(w_wdata)), w_wdata};
`else
    assign w_wword = w_wdata;
`endif

    // Storage is deliberately not reset: contents survive reset.
    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wword;
    end

    assign w_rword = r_mem[bus.rom_addr_in];
    assign w_mask  = w_busy || ({1'b0, bus.rom_addr_in} >= (ADDR_W + 1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (reset)
            r_rdata <= '0;
        else
            r_rdata <= w_mask ? DATA_W'(NOP) : w_rword[DATA_W-1:0];
    end

`ifdef PROGRAM_MEM_PARITY_EN
    logic r_perr;

    // Data and stored parity together must have an even number of ones.
    always_ff @(posedge clk) begin
        if (reset)
            r_perr <= 1'b0;
        else
            r_perr <= !w_mask && (^w_rword);
    end

    assign bus.parity_err = r_perr;
`endif

    assign bus.rom_data_out = r_rdata;
    assign bus.busy         = w_busy;

endmodule

// File: tb/tb_program_mem.sv
// tb_program_mem: scoreboard bench for program_mem with a behavioural memory model.
module tb_program_mem;
    localparam int DW    = 14;
    localparam int AW    = 11;
    localparam int DEPTH = 2048;

    typedef struct packed {logic [DW-1:0] data; logic perr;} fetch_t;
    typedef struct packed {logic [DW-1:0] sum; logic err;} done_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    program_mem_if #(.DATA_W(DW), .ADDR_W(AW)) u_if();

    program_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    fetch_t        fq[$];
    done_t         dq[$];
    logic [DW-1:0] ref_mem [DEPTH];
    bit            ref_known [DEPTH];
    int            ref_ptr;
    logic [DW-1:0] ref_sum;
    logic          ref_err;
    bit            ref_active;
    int            n_checks = 0;
    int            n_fail = 0;
    logic          fetch_req = 1'b0;
    logic          fetch_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) fetch_seen <= fetch_req;

    always @(negedge clk) begin
        fetch_t f;
        done_t  d;
        if (fetch_seen) begin
            if (fq.size() == 0) begin
                check("fetch_queue_underflow", 1, 0);
            end else begin
                f = fq.pop_front();
                check("fetch_data", 32'(u_if.rom_data_out), 32'(f.data));
`ifdef PROGRAM_MEM_PARITY_EN
                check("parity_err", 32'(u_if.parity_err), 32'(f.perr));
`endif
            end
        end
        if (u_if.prog_done) begin
            if (dq.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                d = dq.pop_front();
                check("done_sum", 32'(u_if.prog_sum), 32'(d.sum));
                check("done_err", 32'(u_if.prog_err), 32'(d.err));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] exp, input logic pe);
        fetch_t f;
        f.data = exp;
        f.perr = pe;
        u_if.rom_addr_in = a;
        fq.push_back(f);
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic fetch_known(input int a);
        if (ref_known[a])
            fetch(AW'(a), ref_mem[a], 1'b0);
    endtask

    task automatic start_session(input int base);
        u_if.prog_start = 1'b1;
        u_if.prog_base  = AW'(base);
        if (!ref_active) begin
            ref_ptr    = base;
            ref_sum    = '0;
            ref_err    = 1'b0;
            ref_active = 1'b1;
        end
        tick();
        u_if.prog_start = 1'b0;
    endtask

    task automatic finish_session();
        done_t d;
        d.sum = ref_sum;
        d.err = ref_err;
        ref_active = 1'b0;
        dq.push_back(d);
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic last, input bit gap);
        bit acc;
        if (gap) begin
            u_if.prog_valid = 1'b0;
            tick();
        end
        acc = ref_active;
        u_if.prog_valid = 1'b1;
        u_if.prog_data  = d;
        u_if.prog_last  = last;
        @(negedge clk);
        check("prog_ready", 32'(u_if.prog_ready), 32'(acc));
        tick();
        u_if.prog_valid = 1'b0;
        u_if.prog_last  = 1'b0;
        if (acc) begin
            ref_mem[ref_ptr]   = d;
            ref_known[ref_ptr] = 1'b1;
            ref_sum            = ref_sum + d;
            if (last) begin
                finish_session();
            end else if (ref_ptr == DEPTH - 1) begin
                ref_err = 1'b1;
                finish_session();
            end else begin
                ref_ptr++;
            end
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (u_if.busy && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("busy_cleared", 32'(u_if.busy), 0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base, len;
        int bases[3];
        int lens[3];
        u_if.rom_addr_in = '0;
        u_if.prog_start  = 1'b0;
        u_if.prog_base   = '0;
        u_if.prog_valid  = 1'b0;
        u_if.prog_data   = '0;
        u_if.prog_last   = 1'b0;
        ref_active       = 1'b0;

        repeat (3) tick();
        @(negedge clk);
        check("rst_rom_data_out", 32'(u_if.rom_data_out), 0);
        check("rst_busy",         32'(u_if.busy), 0);
        check("rst_prog_ready",   32'(u_if.prog_ready), 0);
        check("rst_prog_done",    32'(u_if.prog_done), 0);
        check("rst_prog_err",     32'(u_if.prog_err), 0);
        check("rst_prog_sum",     32'(u_if.prog_sum), 0);
        tick();
        reset = 1'b0;
        tick();

        // Basic three-word session from address 0.
        start_session('h000);
        send_word(14'h303B, 1'b0, 1'b0);
        send_word(14'h00A4, 1'b0, 1'b0);
        send_word(14'h01A5, 1'b1, 1'b0);
        wait_idle();
        check("sum_literal", 32'(ref_sum), 32'h3284);
        fetch_known('h002);
        fetch_known('h000);
        fetch_known('h001);

        // Sentinel just past the throttled block proves the pointer stops after 3 words.
        start_session('h023);
        send_word(14'h1234, 1'b1, 1'b0);
        wait_idle();
        start_session('h020);
        send_word(14'h0A0A, 1'b0, 1'b1);
        send_word(14'h1555, 1'b0, 1'b1);
        send_word(14'h2AAA, 1'b1, 1'b1);
        wait_idle();
        for (int a = 'h020; a <= 'h023; a++) fetch_known(a);

        // Overflow at the top of memory: no wrap, third word refused.
        start_session('h7FE);
        send_word(14'h0111, 1'b0, 1'b0);
        send_word(14'h0222, 1'b0, 1'b0);
        send_word(14'h0333, 1'b0, 1'b0);
        wait_idle();
        fetch_known('h7FE);
        fetch_known('h7FF);
        fetch_known('h000);

        // Fetch masked during LOAD; a second prog_start mid-session is ignored.
        start_session('h100);
        fetch('h000, '0, 1'b0);
        send_word(14'h0111, 1'b0, 1'b0);
        start_session('h200);
        fetch('h100, '0, 1'b0);
        send_word(14'h0222, 1'b1, 1'b0);
        wait_idle();
        fetch_known('h100);
        fetch_known('h101);

        // Reset in the middle of a session keeps the words already written.
        start_session('h010);
        send_word(14'h0ABC, 1'b0, 1'b0);
        send_word(14'h1DEF, 1'b0, 1'b0);
        reset = 1'b1;
        ref_active = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_busy",  32'(u_if.busy), 0);
        check("rst_mid_ready", 32'(u_if.prog_ready), 0);
        tick();
        fetch_known('h010);
        fetch_known('h011);

        // Randomised sessions against the model.
        for (int s = 0; s < 3; s++) begin
            base = int'($urandom_range(32'h300, 32'h6F0));
            len  = int'($urandom_range(1, 8));
            bases[s] = base;
            lens[s]  = len;
            start_session(base);
            for (int i = 0; i < len; i++)
                send_word(DW'($urandom), i == len - 1, bit'($urandom_range(0, 1)));
            wait_idle();
        end
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < lens[s]; i++) fetch_known(bases[s] + i);

`ifdef PROGRAM_MEM_PARITY_EN
        dut.r_mem[1] = dut.r_mem[1] ^ 15'h0001;
        fetch('h001, ref_mem[1] ^ 14'h0001, 1'b1);
        fetch_known('h002);
`endif

        tick();
        tick();
        check("fetch_queue_empty", 32'(fq.size()), 0);
        check("done_queue_empty",  32'(dq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_mem.md
Name: program_mem

Overview:
- Parametrised, writable successor to the fixed instruction ROM of the PIC-style core.
- Provides a registered-read instruction fetch port to the core.
- Provides an in-system programming ("burn") port with a valid/ready word handshake, a load FSM, a running checksum and overflow detection.
- The core fetches through this block. The loader (UART or debug bridge) fills it without resynthesis.

Parameters:
- DATA_W, 14, instruction word width.
- ADDR_W, 11, fetch/program address width.
- DEPTH, 2048, number of implemented words; must be ≤ 2**ADDR_W. Addresses ≥ DEPTH are unimplemented.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- rom_addr_in  in  ADDR_W  fetch address.
- rom_data_out  out  DATA_W  fetched instruction, registered.
- busy  out  1  high while programming; the core must stall.
- prog_start  in  1  single-cycle pulse that begins a load session.
- prog_base  in  ADDR_W  first write address, sampled with prog_start.
- prog_valid  in  1  a program word is offered.
- prog_data  in  DATA_W  program word.
- prog_last  in  1  marks the final word of the session.
- prog_ready  out  1  block accepts a word this cycle.
- prog_done  out  1  one-cycle pulse at the end of a session.
- prog_err  out  1  sticky overflow flag for the last session.
- prog_sum  out  DATA_W  sum of accepted words, modulo 2**DATA_W.

Behaviour:
- Reset values: rom_data_out=0, busy=0, prog_ready=0, prog_done=0, prog_err=0, prog_sum=0. FSM goes to IDLE.
- Reset does not clear memory. Contents are undefined until the first programming session.
- Fetch latency is 1 cycle: rom_data_out at edge N+1 = mem[rom_addr_in at edge N].
- Fetch returns 0 (NOP) if the address is ≥ DEPTH, or if busy was high at edge N.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - On prog_start: ptr←prog_base, prog_sum←0, prog_err←0, then go to LOAD.
  - If prog_base ≥ DEPTH: prog_err←1 and go straight to DONE.
- LOAD:
  - prog_ready=1 and busy=1.
  - A word is accepted when prog_valid && prog_ready: mem[ptr]←prog_data, prog_sum←prog_sum+prog_data (mod 2**DATA_W), ptr←ptr+1.
  - An accepted word with prog_last=1 moves the FSM to DONE.
  - If a word is accepted at ptr=DEPTH-1 without prog_last: the write still occurs, prog_err←1, go to DONE. There is no wrap to address 0.
  - prog_start during LOAD is ignored.
  - prog_valid=0 holds the state indefinitely. There is no timeout.
- DONE:
  - prog_ready=0, busy=1, prog_done=1 for exactly one cycle, then return to IDLE.
  - prog_sum and prog_err hold until the next prog_start.
- Outside LOAD: prog_ready=0, and prog_valid is ignored with no write.
- Reset mid-LOAD: go to IDLE. Words already written stay in memory. Partial data are not rolled back.
- The first fetch after busy falls returns newly written data. Read-during-write conflicts cannot occur because fetches are masked while busy.

Optional Feature:
- Macro PROGRAM_MEM_PARITY_EN.
- When defined:
  - Each stored word carries one extra even-parity bit, computed on write.
  - On fetch, parity is checked against the data in the same register stage.
  - A new output parity_err (1 bit, reset 0) pulses high with the affected rom_data_out.
  - Masked (NOP) fetches never flag.
- When undefined: no parity storage, and the parity_err port does not exist.

Decomposition:
- Package program_mem_pkg holds:
  - FSM state enum (IDLE, LOAD, DONE).
  - NOP constant (0).
  - Parity helper function.
- One sub-module, program_mem_loader: FSM, pointer, checksum and error logic. It drives the write enable, address and data into the storage array kept in program_mem.

Test Plan:
- Reset, then fetch addr 0x000 → rom_data_out=0x0000 and busy=0. Reset mid-LOAD after 2 words → IDLE, and those 2 words can be read back.
- Start at base 0x000, send 0x303B, 0x00A4, 0x01A5 (last on the third) → prog_done pulse, prog_sum=0x3284, prog_err=0. Fetch addr 0x002 → 0x01A5 one cycle later.
- Throttled load with prog_valid toggling every other cycle → only valid cycles are written, and ptr increments exactly 3 times.
- Base 0x7FE, send 3 words with no prog_last → 0x7FE and 0x7FF written, prog_err=1, third word not accepted (prog_ready=0), mem[0x000] unchanged.
- Fetch during LOAD → rom_data_out=0x0000. prog_start pulsed mid-LOAD → ignored, ptr and sum unchanged.
- PARITY_EN: force a flipped stored bit at 0x001, fetch 0x001 → parity_err=1 in the same cycle as the data. A clean fetch → parity_err=0.
